// File: rtl/mac_vlg_pkg.sv
// Shared types and constants for the MAC TX path.
// No logic; imported by the buffer, its interface and the bench.
package mac_vlg_pkg;

  typedef logic [15:0] length_t;
  typedef logic [47:0] mac_addr_t;

  typedef struct packed {
    mac_addr_t  dst;
    logic [15:0] ethertype;
    length_t    length;
  } mac_meta_t;

  typedef struct packed {
    logic [7:0] dat;
  } mac_strm_t;

  localparam int MAC_HDR_LEN = 14;

  typedef enum logic [2:0] {
    idle_s,
    load_s,
    wait_ack_s,
    send_s,
    wait_done_s
  } tx_buf_state_t;

endpackage

// File: rtl/mac_vlg_if.sv
// Handshake between the TX buffer and the MAC: rdy/ack offers a frame, req pulls bytes, done closes it.
// Pure wiring; no latency or backpressure of its own.
interface mac_vlg_if;
  import mac_vlg_pkg::*;

  logic      rdy;
  mac_meta_t meta;
  mac_strm_t strm;
  logic      ack;
  logic      req;
  logic      done;

  modport out_tx (output rdy, meta, strm, input ack, req, done);
  modport in_tx  (input rdy, meta, strm, output ack, req, done);
endinterface

// File: rtl/ram_if_dp.sv
// Simple dual-port 2^AW x 8 payload store with a registered read port.
// Read data valid one cycle after re; writer and reader never contend.
module ram_if_dp #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdat,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdat
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
    if (re) rdat <= mem[raddr];
  end

endmodule

// File: rtl/mac_vlg_tx_buf.sv
// Store-and-forward frame buffer in front of the MAC TX: fill one frame, offer it, stream it out zero-padded.
// Byte k appears one cycle after the k-th req cycle; in_rdy is low from first byte until the MAC signals done.
module mac_vlg_tx_buf
  import mac_vlg_pkg::*;
#(
  parameter int AW      = 11,
  parameter bit VERBOSE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_dat,
  input  logic       in_val,
  input  mac_meta_t  in_meta,
  output logic       in_rdy,
  output logic       err,
  mac_vlg_if.out_tx  mac
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  tx_buf_state_t state, nxt;
  logic [AW:0]   wr_cnt;
  logic [AW:0]   rd_addr;
  logic          drop;
  logic          req_q;
  logic          pad_q;
  mac_meta_t     meta_q;
  logic [7:0]    ram_rdat;

  logic accept, wr_en, ovf, rd_en, load_end, ack_take;

  always_ff @(posedge clk) begin
    if (rst) state <= idle_s;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      idle_s:      if (in_val && !drop) nxt = load_s;
      load_s: begin
        if (!in_val)             nxt = wait_ack_s;
        else if (wr_cnt == FULL) nxt = idle_s;
      end
      wait_ack_s:  if (mac.ack) nxt = send_s;
      send_s:      if (req_q && !mac.req) nxt = wait_done_s;
      wait_done_s: if (mac.done) nxt = idle_s;
      default:     nxt = idle_s;
    endcase
  end

  always_comb begin
    in_rdy   = (state == idle_s) && !drop;
    accept   = in_rdy && in_val;
    wr_en    = accept || ((state == load_s) && in_val && (wr_cnt != FULL));
    ovf      = (state == load_s) && in_val && (wr_cnt == FULL);
    load_end = (state == load_s) && !in_val;
    ack_take = (state == wait_ack_s) && mac.ack;
    rd_en    = (state == send_s) && mac.req;
  end

  // drop holds off the next frame until the overflowing run of in_val ends
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_addr <= '0;
      drop    <= 1'b0;
      err     <= 1'b0;
      req_q   <= 1'b0;
      pad_q   <= 1'b1;
      meta_q  <= '0;
    end else begin
      err   <= ovf;
      req_q <= mac.req;
      if (ovf)          drop <= 1'b1;
      else if (!in_val) drop <= 1'b0;

      if (accept) begin
        meta_q <= in_meta;
        wr_cnt <= (AW+1)'(1);
      end else if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (load_end) meta_q.length <= length_t'(wr_cnt);

      if (ack_take) begin
        rd_addr <= '0;
      end else if (rd_en) begin
        pad_q <= length_t'(rd_addr) >= meta_q.length;
        if (rd_addr != '1) rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  ram_if_dp #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (accept ? '0 : wr_cnt[AW-1:0]),
    .wdat  (in_dat),
    .re    (rd_en),
    .raddr (rd_addr[AW-1:0]),
    .rdat  (ram_rdat)
  );

  assign mac.rdy  = (state == wait_ack_s);
  assign mac.meta = meta_q;
  assign mac.strm = '{dat: (pad_q ? 8'h00 : ram_rdat)};

`ifndef SYNTHESIS
  if (VERBOSE) begin : g_verbose
    always_ff @(posedge clk) begin
      if (!rst && ack_take)
        $display("mac_vlg_tx_buf: dst=%012h type=%04h len=%0d",
                 meta_q.dst, meta_q.ethertype, meta_q.length);
    end
  end
`endif

endmodule

// File: tb/tb_mac_vlg_tx_buf.sv
// Directed bench for mac_vlg_tx_buf: frames are modelled as byte queues, the MAC side is played by tasks.
// One compare process checks stream bytes and offered metadata every cycle against that model.
module tb_mac_vlg_tx_buf;
  import mac_vlg_pkg::*;

  localparam int RAM_BYTES = 2048;
  localparam int BUDGET    = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_dat = 8'h00;
  logic       in_val = 1'b0;
  mac_meta_t  in_meta = '0;
  logic       in_rdy;
  logic       err;

  mac_vlg_if mac_if ();

  mac_vlg_tx_buf #(.AW(11), .VERBOSE(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_dat  (in_dat),
    .in_val  (in_val),
    .in_meta (in_meta),
    .in_rdy  (in_rdy),
    .err     (err),
    .mac     (mac_if)
  );

  always #5 clk = ~clk;

  int         nvec = 0;
  int         nmis = 0;
  logic [7:0] frame_q [$];
  logic [7:0] got_q [$];
  mac_meta_t  exp_meta = '0;
  bit         sending = 1'b0;
  bit         chk_en = 1'b0;
  int         rd_idx = 0;
  int         err_cnt = 0;
  int         rdy_cnt = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: byte i of the stream is payload[i] inside the frame, zero beyond it
  initial begin
    bit         req_seen;
    logic [7:0] exp_b;
    forever begin
      @(posedge clk);
      req_seen = sending && (mac_if.req === 1'b1);
      @(negedge clk);
      if (chk_en) begin
        if (req_seen) begin
          exp_b = (rd_idx < frame_q.size()) ? frame_q[rd_idx] : 8'h00;
          chk("strm_dat", mac_if.strm.dat, exp_b);
          got_q.push_back(mac_if.strm.dat);
          rd_idx++;
        end
        if (mac_if.rdy === 1'b1) begin
          chk("meta", mac_if.meta, exp_meta);
          chk("in_rdy_busy", in_rdy, 1'b0);
          rdy_cnt++;
        end
        if (err === 1'b1) err_cnt++;
      end
    end
  end

  task automatic send_frame(input int n, input logic [7:0] first, input logic [15:0] etype);
    int        t;
    mac_meta_t m;
    t = 0;
    while (in_rdy !== 1'b1 && t < BUDGET) begin
      @(posedge clk); #1; t++;
    end
    chk("in_rdy_wait", t < BUDGET, 1'b1);
    frame_q.delete();
    m = '{dst: 48'h0200_5E00_0000 | 48'(n), ethertype: etype, length: 16'hBEEF};
    for (int i = 0; i < n; i++) begin
      in_val  = 1'b1;
      in_dat  = first + 8'(i);
      in_meta = (i == 0) ? m : '1;
      if (n <= RAM_BYTES) frame_q.push_back(in_dat);
      @(posedge clk); #1;
    end
    in_val  = 1'b0;
    in_dat  = 8'h00;
    in_meta = '0;
    m.length = 16'(n);
    exp_meta = m;
  endtask

  task automatic mac_xfer(input int nreq, input int rst_at, input bit spurious_done);
    int t;
    t = 0;
    while (mac_if.rdy !== 1'b1 && t < BUDGET) begin
      @(posedge clk); #1; t++;
    end
    chk("mac_rdy_wait", t < BUDGET, 1'b1);
    if (t >= BUDGET) return;
    if (spurious_done) begin
      mac_if.done = 1'b1;
      @(posedge clk); #1;
      mac_if.done = 1'b0;
      @(negedge clk);
      chk("rdy_after_spurious_done", mac_if.rdy, 1'b1);
    end
    mac_if.ack = 1'b1;
    @(posedge clk); #1;
    mac_if.ack = 1'b0;
    got_q.delete();
    rd_idx  = 0;
    sending = 1'b1;
    @(negedge clk);
    chk("rdy_clear_after_ack", mac_if.rdy, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < nreq; i++) begin
      if (i == rst_at) begin
        mac_if.req = 1'b0;
        sending    = 1'b0;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_send_mac_rdy", mac_if.rdy, 1'b0);
        chk("rst_send_in_rdy", in_rdy, 1'b1);
        chk("rst_send_dat", mac_if.strm.dat, 8'h00);
        chk("rst_send_meta", mac_if.meta, 80'h0);
        frame_q.delete();
        return;
      end
      mac_if.req = 1'b1;
      @(posedge clk); #1;
    end
    mac_if.req = 1'b0;
    @(posedge clk); #1;
    sending = 1'b0;
    mac_if.done = 1'b1;
    @(negedge clk);
    chk("in_rdy_before_done", in_rdy, 1'b0);
    @(posedge clk); #1;
    mac_if.done = 1'b0;
    @(negedge clk);
    chk("in_rdy_after_done", in_rdy, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mac_if.ack  = 1'b0;
    mac_if.req  = 1'b0;
    mac_if.done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_rdy", in_rdy, 1'b1);
    chk("reset_mac_rdy", mac_if.rdy, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_dat", mac_if.strm.dat, 8'h00);
    chk("reset_meta", mac_if.meta, 80'h0);
    chk_en = 1'b1;

    // ack with nothing buffered must not start anything
    @(posedge clk); #1;
    mac_if.ack = 1'b1;
    @(posedge clk); #1;
    mac_if.ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_mac_rdy", mac_if.rdy, 1'b0);
    chk("idle_ack_in_rdy", in_rdy, 1'b1);

    // 10 bytes 01..0A, padded to 60 on the stream
    send_frame(10, 8'h01, 16'h0800);
    @(posedge clk); @(negedge clk);
    chk("len10", mac_if.meta.length, 16'd10);
    chk("type0800", mac_if.meta.ethertype, 16'h0800);
    mac_xfer(60, -1, 1'b0);
    chk("f10_count", got_q.size(), 60);
    chk("f10_byte0", got_q[0], 8'h01);
    chk("f10_byte9", got_q[9], 8'h0A);
    chk("f10_pad10", got_q[10], 8'h00);
    chk("f10_pad59", got_q[59], 8'h00);

    // full-size payload, with a stray done while the frame is offered
    send_frame(1500, 8'h00, 16'h86DD);
    @(posedge clk); @(negedge clk);
    chk("len1500", mac_if.meta.length, 16'd1500);
    mac_xfer(1500, -1, 1'b1);
    chk("f1500_count", got_q.size(), 1500);
    chk("f1500_byte1499", got_q[1499], 8'hDB);

    // one byte past capacity
    err_cnt = 0;
    rdy_cnt = 0;
    send_frame(2049, 8'h10, 16'h0800);
    @(negedge clk);
    chk("ovf_in_rdy_hold", in_rdy, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("ovf_in_rdy_back", in_rdy, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ovf_err_pulses", err_cnt, 1);
    chk("ovf_no_mac_rdy", rdy_cnt, 0);
    @(posedge clk); #1;
    send_frame(20, 8'hA0, 16'h0806);
    mac_xfer(60, -1, 1'b0);
    chk("f20_byte19", got_q[19], 8'hB3);

    // reset partway through streaming, then recover
    send_frame(600, 8'h33, 16'h0800);
    mac_xfer(600, 300, 1'b0);
    @(posedge clk); #1;
    send_frame(60, 8'h5A, 16'h0800);
    mac_xfer(60, -1, 1'b0);
    chk("f60_count", got_q.size(), 60);

    // back-to-back minimum and 64-byte payloads
    send_frame(46, 8'hC0, 16'h0800);
    mac_xfer(60, -1, 1'b0);
    chk("f46_byte45", got_q[45], 8'hED);
    send_frame(64, 8'h01, 16'h0800);
    mac_xfer(64, -1, 1'b0);
    chk("f64_byte63", got_q[63], 8'h40);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
